treemux_rr_arb: RTL and testbench

- N-channel to 1-channel registered mux for WIDTH-bit beats, with per-channel valid/ready handshakes and back-pressure.
- Fair round-robin arbitration with optional packet lock on last_in.
- Reports the source index of every output beat.
- Sits where several producers merge onto one shared link.
- Unlike a priority-select mux, no beat is ever dropped or overwritten.

---
 rtl/treemux_rr_arb.sv | 120 ++++++++++++
 tb/tb_treemux_rr_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/treemux_rr_arb.sv
// rtl/treemux_rr_arb.sv - N-to-1 registered round-robin mux with optional packet lock
// One output register slot; grant is combinational from valid_in, pointer and lock.
module treemux_rr_arb #(
  parameter int WIDTH        = 72,
  parameter int N            = 4,
  parameter int IDX_W        = (N > 1 ? $clog2(N) : 1),
  parameter int LOCK_ON_LAST = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     data_in [N-1:0],
  input  logic [N-1:0]         valid_in,
  input  logic [N-1:0]         last_in,
  output logic [N-1:0]         ready_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic                 last_out,
  output logic [IDX_W-1:0]     src_out,
  input  logic                 ready_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_W      = (IDX_W + 1)'(N);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic             load_en;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   cand;
  logic             accept;
  logic             ends_grant;

  assign load_en = !valid_q || ready_out;

  // Scan from the farthest offset down so the channel nearest ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (lock_q) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int j = N - 1; j >= 0; j--) begin
        cand = {1'b0, ptr_q} + (IDX_W + 1)'(j);
        if (cand >= N_W) cand = cand - N_W;
        if (valid_in[cand[IDX_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ready_in = '0;
    if (grant_vld && load_en && RST_N) ready_in[grant_idx] = 1'b1;
  end

  assign accept     = |(valid_in & ready_in);
  assign ends_grant = (LOCK_ON_LAST == 0) || last_in[grant_idx];

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    src_d      = src_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_in[grant_idx];
      last_d  = last_in[grant_idx];
      src_d   = grant_idx;
      if (ends_grant) begin
        ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        lock_d = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = grant_idx;
      end
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      src_q      <= '0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      src_q      <= src_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign src_out   = src_q;

endmodule

// File: tb/tb_treemux_rr_arb.sv
// tb/tb_treemux_rr_arb.sv - scoreboard bench for treemux_rr_arb (locked and per-beat instances)
module tb_treemux_rr_arb;
  localparam int N = 4;
  localparam int W = 72;

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [W-1:0] data; logic last; logic [1:0] src; } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [W-1:0] din0 [N-1:0];
  logic [W-1:0] din1 [N-1:0];
  logic [N-1:0] vin0, lin0, rdy0, vin1, lin1, rdy1;
  logic [W-1:0] dout0, dout1;
  logic vout0, lout0, vout1, lout1, rout0, rout1;
  logic [1:0] src0, src1;

  beat_t chq [2*N][$];
  exp_t  exp0[$];
  exp_t  exp1[$];
  int    pop_cyc0[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  treemux_rr_arb #(.WIDTH(W), .N(N), .LOCK_ON_LAST(1)) u_lock (
    .CLK(CLK), .RST_N(RST_N), .data_in(din0), .valid_in(vin0), .last_in(lin0),
    .ready_in(rdy0), .data_out(dout0), .valid_out(vout0), .last_out(lout0),
    .src_out(src0), .ready_out(rout0));

  treemux_rr_arb #(.WIDTH(W), .N(N), .LOCK_ON_LAST(0)) u_beat (
    .CLK(CLK), .RST_N(RST_N), .data_in(din1), .valid_in(vin1), .last_in(lin1),
    .ready_in(rdy1), .data_out(dout1), .valid_out(vout1), .last_out(lout1),
    .src_out(src1), .ready_out(rout1));

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(int d, int ch, logic [W-1:0] data, logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    chq[d*N+ch].push_back(b);
  endtask

  task automatic expect_b(int d, int src, logic [W-1:0] data, logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    e.src  = 2'(src);
    if (d == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic wait_empty(int d, string name);
    int n = 0;
    while ((d == 0 ? exp0.size() : exp1.size()) != 0 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(name, 128'(d == 0 ? exp0.size() : exp1.size()), 128'(0));
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    for (int i = 0; i < 2*N; i++) chq[i].delete();
    exp0.delete();
    exp1.delete();
    pop_cyc0.delete();
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  // Producer model: present queue heads, retire a head once it was seen accepted.
  initial begin
    logic [N-1:0] f0, f1;
    forever begin
      @(negedge CLK);
      f0 = vin0 & rdy0;
      f1 = vin1 & rdy1;
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        f0 = '0;
        f1 = '0;
      end
      for (int c = 0; c < N; c++) begin
        if (f0[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        if (f1[c] && chq[N+c].size() > 0) void'(chq[N+c].pop_front());
        vin0[c] = chq[c].size() > 0;
        vin1[c] = chq[N+c].size() > 0;
        if (chq[c].size() > 0) begin
          din0[c] = chq[c][0].data;
          lin0[c] = chq[c][0].last;
        end
        if (chq[N+c].size() > 0) begin
          din1[c] = chq[N+c][0].data;
          lin1[c] = chq[N+c][0].last;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && vout0 && rout0) begin
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lock_beat_unexpected: got src %0d data %0h, required no beat", src0, dout0);
        end else begin
          e = exp0.pop_front();
          chk("lock_beat", 128'({dout0, lout0, src0}), 128'(e));
          pop_cyc0.push_back(cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && vout1 && rout1) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_beat_unexpected: got src %0d data %0h, required no beat", src1, dout1);
        end else begin
          e = exp1.pop_front();
          chk("beat_beat", 128'({dout1, lout1, src1}), 128'(e));
        end
      end
    end
  end

  task automatic lock_scenario(int d);
    int n;
    expect_b(d, 1, 72'h11, 1'b1);
    push(d, 1, 72'h11, 1'b1);
    wait_empty(d, "lock_setup_drain");
    if (d == 0) begin
      expect_b(0, 2, 72'hA1, 1'b0);
      expect_b(0, 2, 72'hA2, 1'b0);
      expect_b(0, 2, 72'hA3, 1'b0);
      expect_b(0, 2, 72'hA4, 1'b1);
      expect_b(0, 3, 72'h130, 1'b1);
      expect_b(0, 0, 72'h100, 1'b1);
      expect_b(0, 1, 72'h110, 1'b1);
    end else begin
      expect_b(1, 2, 72'hA1, 1'b0);
      expect_b(1, 3, 72'h130, 1'b1);
      expect_b(1, 0, 72'h100, 1'b1);
      expect_b(1, 1, 72'h110, 1'b1);
      expect_b(1, 2, 72'hA2, 1'b0);
      expect_b(1, 2, 72'hA3, 1'b0);
      expect_b(1, 2, 72'hA4, 1'b1);
    end
    push(d, 0, 72'h100, 1'b1);
    push(d, 1, 72'h110, 1'b1);
    push(d, 3, 72'h130, 1'b1);
    push(d, 2, 72'hA1, 1'b0);
    push(d, 2, 72'hA2, 1'b0);
    n = 0;
    while (chq[d*N+2].size() != 0 && n < 100) begin
      @(posedge CLK);
      #2;
      n++;
    end
    chk("lock_first_half_taken", 128'(chq[d*N+2].size()), 128'(0));
    repeat (2) begin
      @(negedge CLK);
      if (d == 0) chk("lock_gap_others_ready", 128'(rdy0 & 4'b1011), 128'(0));
    end
    @(posedge CLK);
    #2;
    push(d, 2, 72'hA3, 1'b0);
    push(d, 2, 72'hA4, 1'b1);
    wait_empty(d, "lock_scenario_drain");
  endtask

  initial begin
    int n;
    vin0 = '0; vin1 = '0; lin0 = '0; lin1 = '0;
    for (int c = 0; c < N; c++) begin
      din0[c] = '0;
      din1[c] = '0;
    end
    rout0 = 1'b1;
    rout1 = 1'b1;
    #1;
    RST_N = 1'b0;
    #2;
    chk("rst_valid_out", 128'(vout0), 128'(0));
    chk("rst_data_out", 128'(dout0), 128'(0));
    chk("rst_last_out", 128'(lout0), 128'(0));
    chk("rst_src_out", 128'(src0), 128'(0));
    chk("rst_ready_in", 128'({rdy1, rdy0}), 128'(0));
    chk("rst_valid_out_beat", 128'(vout1), 128'(0));
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;

    // Reset mid-packet on ch1
    expect_b(0, 1, 72'h81, 1'b0);
    expect_b(0, 1, 72'h82, 1'b0);
    push(0, 1, 72'h81, 1'b0);
    push(0, 1, 72'h82, 1'b0);
    push(0, 1, 72'h83, 1'b1);
    wait_empty(0, "midpkt_two_beats");
    #1;
    RST_N = 1'b0;
    for (int i = 0; i < 2*N; i++) chq[i].delete();
    #1;
    chk("midpkt_rst_valid_out", 128'(vout0), 128'(0));
    chk("midpkt_rst_ready_in", 128'(rdy0), 128'(0));
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    expect_b(0, 0, 72'h70, 1'b1);
    expect_b(0, 2, 72'h72, 1'b1);
    push(0, 0, 72'h70, 1'b1);
    push(0, 2, 72'h72, 1'b1);
    wait_empty(0, "post_reset_order");

    // Fairness with single-beat packets
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < N; ch++) begin
        expect_b(0, ch, 72'(32'h200 + ch*16 + k), 1'b1);
        push(0, ch, 72'(32'h200 + ch*16 + k), 1'b1);
      end
    wait_empty(0, "fair_drain");
    chk("fair_beat_count", 128'(pop_cyc0.size()), 128'(8));
    if (pop_cyc0.size() == 8)
      chk("fair_one_per_cycle", 128'(pop_cyc0[7] - pop_cyc0[0]), 128'(7));

    // Packet lock, then the same stimulus per-beat
    do_reset();
    lock_scenario(0);
    do_reset();
    lock_scenario(1);

    // Back-pressure with 0xA5 held from ch1
    do_reset();
    rout0 = 1'b0;
    expect_b(0, 1, 72'hA5, 1'b1);
    expect_b(0, 3, 72'h3C, 1'b1);
    push(0, 1, 72'hA5, 1'b1);
    n = 0;
    while (!vout0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_loaded", 128'(vout0), 128'(1));
    push(0, 3, 72'h3C, 1'b1);
    repeat (5) begin
      @(negedge CLK);
      chk("bp_hold", 128'({vout0, src0, dout0}), {53'd0, 1'b1, 2'd1, 72'hA5});
      chk("bp_ready_in", 128'(rdy0), 128'(0));
    end
    @(posedge CLK);
    #2;
    rout0 = 1'b1;
    @(negedge CLK);
    chk("bp_release_accept", 128'(rdy0 & vin0), 128'(4'b1000));
    wait_empty(0, "bp_drain");

    // Wrap and sparse valid
    do_reset();
    expect_b(0, 2, 72'h52, 1'b1);
    push(0, 2, 72'h52, 1'b1);
    wait_empty(0, "wrap_setup");
    expect_b(0, 1, 72'h51, 1'b1);
    push(0, 1, 72'h51, 1'b1);
    wait_empty(0, "wrap_ch1");
    expect_b(0, 2, 72'h62, 1'b1);
    expect_b(0, 0, 72'h60, 1'b1);
    push(0, 0, 72'h60, 1'b1);
    push(0, 2, 72'h62, 1'b1);
    wait_empty(0, "wrap_ch2_before_ch0");

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1);
  end

endmodule
